decoder_scan_ctrl: RTL and testbench

Round-robin scan controller that drives the `x[1:0]` select and `En` enable inputs of the 2-to-4 dataflow decoder, which sits directly downstream. It cycles through the four decoder outputs, gives each enabled channel a fixed time slot, and forces a blanking gap at the start of every slot so that two outputs are never active at once. This supports the multiplexed four-digit display.

---
 rtl/decoder_scan_ctrl.sv | 117 +++++++++++
 tb/tb_decoder_scan_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_ctrl.sv
// Round-robin scan controller for a 2-to-4 decoder: walks the enabled channels,
// one DIV-cycle slot each, with a BLANK-cycle enable gap at the start of every slot.
module decoder_scan_ctrl #(
  parameter int unsigned DIV   = 1000,
  parameter int unsigned BLANK = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] mask,
  output logic [1:0] sel,
  output logic       en,
  output logic       slot_start,
  output logic       frame_done
);

  localparam int unsigned CW = $clog2(DIV);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BLK  = 2'd1,
    ON   = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [1:0]    sel_d;
  logic          en_d, slot_start_d, frame_done_d;
  logic [1:0]    nxt;

  // First enabled channel searching s, s+1, s+2, s+3 (mod 4).
  function automatic logic [1:0] first_ch(input logic [3:0] m, input logic [1:0] s);
    logic [1:0] c;
    first_ch = s;
    for (int k = 3; k >= 0; k--) begin
      c = s + 2'(k);
      if (m[c]) first_ch = c;
    end
  endfunction

  // First enabled channel searching s+1, s+2, s+3, s (mod 4).
  function automatic logic [1:0] next_ch(input logic [3:0] m, input logic [1:0] s);
    logic [1:0] c;
    next_ch = s;
    for (int k = 4; k >= 1; k--) begin
      c = s + 2'(k);
      if (m[c]) next_ch = c;
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sel        <= 2'd0;
      en         <= 1'b0;
      slot_start <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      sel        <= sel_d;
      en         <= en_d;
      slot_start <= slot_start_d;
      frame_done <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    sel_d        = sel;
    slot_start_d = 1'b0;
    frame_done_d = 1'b0;
    nxt          = next_ch(mask, sel);

    if (!run) begin
      // Dropping run always wins, even over an end of slot.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mask != 4'd0) begin
            sel_d        = first_ch(mask, sel);
            cnt_d        = '0;
            state_d      = (BLANK == 0) ? ON : BLK;
            slot_start_d = 1'b1;
          end
        end
        BLK, ON: begin
          if (cnt == CW'(DIV - 1)) begin
            cnt_d = '0;
            if (mask == 4'd0) begin
              state_d = IDLE;
            end else begin
              sel_d        = nxt;
              state_d      = (BLANK == 0) ? ON : BLK;
              slot_start_d = 1'b1;
              frame_done_d = (nxt <= sel);
            end
          end else begin
            cnt_d = cnt + CW'(1);
            if (state == BLK && BLANK > 0 && cnt == CW'(BLANK - 1)) state_d = ON;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    en_d = (state_d == ON);
  end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Scoreboard bench for decoder_scan_ctrl: a slot-position model predicts each
// cycle's outputs for a BLANK=2 and a BLANK=0 instance (DIV=8).
module tb_decoder_scan_ctrl;

  localparam int unsigned DIV = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [3:0] mask;
  logic [1:0] sel_a, sel_b;
  logic       en_a, en_b, ss_a, ss_b, fd_a, fd_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0] q_a[$];
  logic [4:0] q_b[$];

  bit         m_act[2];
  int         m_pos[2];
  logic [1:0] m_sel[2];
  logic       m_ss[2];
  logic       m_fd[2];

  always #5 clk = ~clk;

  decoder_scan_ctrl #(.DIV(DIV), .BLANK(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .run(run), .mask(mask),
    .sel(sel_a), .en(en_a), .slot_start(ss_a), .frame_done(fd_a)
  );

  decoder_scan_ctrl #(.DIV(DIV), .BLANK(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .run(run), .mask(mask),
    .sel(sel_b), .en(en_b), .slot_start(ss_b), .frame_done(fd_b)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [1:0] m_first(input logic [3:0] m, input logic [1:0] s);
    for (int k = 0; k < 4; k++) if (m[2'(s + 2'(k))]) return 2'(s + 2'(k));
    return s;
  endfunction

  function automatic logic [1:0] m_next(input logic [3:0] m, input logic [1:0] s);
    for (int k = 1; k <= 4; k++) if (m[2'(s + 2'(k))]) return 2'(s + 2'(k));
    return s;
  endfunction

  function automatic int blank_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic logic [4:0] m_out(input int i);
    logic e;
    e = m_act[i] && (m_pos[i] >= blank_of(i));
    return {m_sel[i], e, m_ss[i], m_fd[i]};
  endfunction

  // Advance model i by one clock edge using the inputs currently applied.
  task automatic m_edge(input int i);
    logic [1:0] ns;
    m_ss[i] = 1'b0;
    m_fd[i] = 1'b0;
    if (!rst_n) begin
      m_act[i] = 1'b0; m_pos[i] = 0; m_sel[i] = 2'd0;
    end else if (!run) begin
      m_act[i] = 1'b0; m_pos[i] = 0;
    end else if (!m_act[i]) begin
      if (mask != 4'd0) begin
        m_sel[i] = m_first(mask, m_sel[i]);
        m_act[i] = 1'b1; m_pos[i] = 0; m_ss[i] = 1'b1;
      end
    end else if (m_pos[i] == DIV - 1) begin
      m_pos[i] = 0;
      if (mask == 4'd0) begin
        m_act[i] = 1'b0;
      end else begin
        ns = m_next(mask, m_sel[i]);
        m_fd[i] = (ns <= m_sel[i]);
        m_sel[i] = ns;
        m_ss[i] = 1'b1;
      end
    end else begin
      m_pos[i]++;
    end
  endtask

  task automatic step();
    logic [4:0] ea, eb;
    m_edge(0);
    m_edge(1);
    q_a.push_back(m_out(0));
    q_b.push_back(m_out(1));
    @(posedge clk);
    #1;
    ea = q_a.pop_front();
    eb = q_b.pop_front();
    check_eq("blank2", 8'({sel_a, en_a, ss_a, fd_a}), 8'(ea));
    check_eq("blank0", 8'({sel_b, en_b, ss_b, fd_b}), 8'(eb));
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Step until instance 0 reaches the given channel/position; a miss counts as a failure.
  task automatic step_until(input logic [1:0] s, input bit any_sel, input int pos);
    int budget;
    budget = 64;
    while (!(m_act[0] && m_pos[0] == pos && (any_sel || m_sel[0] == s)) && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) check_eq("wait_timeout", 8'd1, 8'd0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 1'b0; m_pos[i] = 0; m_sel[i] = 2'd0; m_ss[i] = 1'b0; m_fd[i] = 1'b0;
    end
    rst_n = 1'b0;
    run   = 1'b0;
    mask  = 4'd0;
    #12;
    check_eq("reset_a", 8'({sel_a, en_a, ss_a, fd_a}), 8'd0);
    check_eq("reset_b", 8'({sel_b, en_b, ss_b, fd_b}), 8'd0);
    rst_n = 1'b1;
    steps(2);

    // Full scan.
    run = 1'b1; mask = 4'b1111;
    steps(42);

    // Sparse mask.
    mask = 4'b1010;
    steps(40);

    // Mask cleared mid-slot: slot completes, then idle with sel held.
    step_until(2'd0, 1'b1, 4);
    mask = 4'b0000;
    steps(12);

    // Run drop at cnt=5 of sel=2, then resume.
    mask = 4'b1111;
    step_until(2'd2, 1'b0, 5);
    run = 1'b0;
    steps(3);
    run = 1'b1;
    steps(12);

    // Single channel.
    mask = 4'b0100;
    steps(26);

    // Asynchronous reset mid-slot with en high.
    mask = 4'b1111;
    step_until(2'd0, 1'b1, 3);
    check_eq("pre_rst_en", 8'(en_a), 8'd1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_a", 8'({sel_a, en_a, ss_a, fd_a}), 8'd0);
    check_eq("async_rst_b", 8'({sel_b, en_b, ss_b, fd_b}), 8'd0);
    steps(2);
    rst_n = 1'b1;
    steps(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
